// File: rtl/warp_issue_scheduler_if.sv
// Issue handshake bundle between the per-warp ready logic, the warp issue
// scheduler and the downstream issue stage.
//   master : ready producer / issue consumer (drives warp_rdy, flush, issue_ack)
//   slave  : the scheduler (drives issue_vld, issue_grt, issue_wid)
interface warp_issue_scheduler_if #(
    parameter int NUM_WARPS = 8
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NUM_WARPS-1:0] warp_rdy;
    logic                 flush;
    logic                 issue_ack;
    logic                 issue_vld;
    logic [NUM_WARPS-1:0] issue_grt;
    logic [WID_W-1:0]     issue_wid;

    modport master (
        output warp_rdy,
        output flush,
        output issue_ack,
        input  issue_vld,
        input  issue_grt,
        input  issue_wid
    );

    modport slave (
        input  warp_rdy,
        input  flush,
        input  issue_ack,
        output issue_vld,
        output issue_grt,
        output issue_wid
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Registered round-robin warp issue scheduler.
// Picks the first ready warp scanning circularly from ptr, presents it with a
// valid/ack handshake and holds the grant stable under back-pressure.
// Optional build macro: GREEDY_EN lets one warp issue up to MAX_BURST times in
// a row while it stays ready; undefined gives pure round-robin.
//
// state | meaning
// IDLE  | issue_vld=0, arbitrate every cycle
// HOLD  | issue_vld=1, grant frozen until issue_ack
module warp_issue_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    warp_issue_scheduler_if.slave bus
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    // Elaboration-time sanity on the parameter ranges.
    if (NUM_WARPS < 2) begin : g_bad_num_warps
        $error("warp_issue_scheduler: NUM_WARPS must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("warp_issue_scheduler: MAX_BURST must be >= 1");
    end

    logic [WID_W-1:0] ptr;
    logic [WID_W-1:0] scan_base;
    logic [WID_W-1:0] pick_wid;
    logic             pick_found;

    function automatic logic [WID_W-1:0] inc_wrap(input logic [WID_W-1:0] w);
        return (int'(w) == NUM_WARPS - 1) ? '0 : w + 1'b1;
    endfunction

    // Circular first-set scan; after an ack the scan starts just past the
    // warp being retired, which is the value ptr is about to take.
    always_comb begin
        int idx;
        idx        = 0;
        scan_base  = bus.issue_vld ? inc_wrap(bus.issue_wid) : ptr;
        pick_found = 1'b0;
        pick_wid   = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = (int'(scan_base) + k) % NUM_WARPS;
            if (!pick_found && bus.warp_rdy[idx]) begin
                pick_found = 1'b1;
                pick_wid   = WID_W'(idx);
            end
        end
    end

`ifdef GREEDY_EN
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [BC_W-1:0] burst_cnt;
    logic            keep_grant;

    // Re-grant the acked warp while it stays ready and the burst budget lasts.
    always_comb begin
        keep_grant = bus.issue_vld && bus.issue_ack &&
                     bus.warp_rdy[bus.issue_wid] &&
                     (int'(burst_cnt) + 1 < MAX_BURST);
    end

    // Grant/pointer/burst state: rst > flush > hold > arbitrate.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            burst_cnt     <= '0;
            bus.issue_vld <= 1'b0;
            bus.issue_grt <= '0;
            bus.issue_wid <= '0;
        end else if (bus.flush) begin
            burst_cnt     <= '0;
            bus.issue_vld <= 1'b0;
            bus.issue_grt <= '0;
            bus.issue_wid <= '0;
        end else if (keep_grant) begin
            burst_cnt <= burst_cnt + 1'b1;
        end else if (!bus.issue_vld || bus.issue_ack) begin
            if (bus.issue_vld) begin
                ptr <= scan_base;
            end
            burst_cnt     <= '0;
            bus.issue_vld <= pick_found;
            bus.issue_grt <= pick_found ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << pick_wid) : '0;
            bus.issue_wid <= pick_found ? pick_wid : '0;
        end
    end
`else
    // Grant/pointer state: rst > flush > hold > arbitrate.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            bus.issue_vld <= 1'b0;
            bus.issue_grt <= '0;
            bus.issue_wid <= '0;
        end else if (bus.flush) begin
            bus.issue_vld <= 1'b0;
            bus.issue_grt <= '0;
            bus.issue_wid <= '0;
        end else if (!bus.issue_vld || bus.issue_ack) begin
            if (bus.issue_vld) begin
                ptr <= scan_base;
            end
            bus.issue_vld <= pick_found;
            bus.issue_grt <= pick_found ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << pick_wid) : '0;
            bus.issue_wid <= pick_found ? pick_wid : '0;
        end
    end
`endif
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Self-checking bench for warp_issue_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural model of the scheduler.
module tb_warp_issue_scheduler;
    localparam int N  = 8;
    localparam int MB = 4;

    logic clk;
    logic rst;

    warp_issue_scheduler_if #(.NUM_WARPS(N)) bus ();

    warp_issue_scheduler #(.NUM_WARPS(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model state (plain integers).
    int m_vld;
    int m_wid;
    int m_ptr;
    int m_burst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of scheduler behaviour from the rules: reset, flush, greedy
    // hold, otherwise round-robin pick starting after the retired warp.
    task automatic model_update(input bit r, input bit f, input bit a, input logic [N-1:0] rdy);
        bit keep;
        int base;
        int found;
        if (r) begin
            m_vld = 0; m_wid = 0; m_ptr = 0; m_burst = 0;
        end else if (f) begin
            m_vld = 0; m_wid = 0; m_burst = 0;
        end else if (m_vld == 0 || a) begin
            keep = 1'b0;
`ifdef GREEDY_EN
            keep = (m_vld != 0) && rdy[m_wid] && (m_burst + 1 < MB);
`endif
            if (keep) begin
                m_burst++;
            end else begin
                base = (m_vld != 0) ? (m_wid + 1) % N : m_ptr;
                if (m_vld != 0) m_ptr = base;
                found = -1;
                for (int k = 0; k < N; k++) begin
                    if (found < 0 && rdy[(base + k) % N]) found = (base + k) % N;
                end
                m_burst = 0;
                m_vld   = (found >= 0) ? 1 : 0;
                m_wid   = (found >= 0) ? found : 0;
            end
        end
    endtask

    // Drive inputs at negedge, let one edge pass, compare against the model.
    task automatic step(input bit r, input bit f, input bit a, input logic [N-1:0] rdy);
        logic [31:0] exp_grt;
        @(negedge clk);
        rst           = r;
        bus.flush     = f;
        bus.issue_ack = a;
        bus.warp_rdy  = rdy;
        @(posedge clk);
        model_update(r, f, a, rdy);
        #1;
        exp_grt = (m_vld != 0) ? (32'd1 << m_wid) : 32'd0;
        chk("vld", 32'(bus.issue_vld), 32'(m_vld));
        chk("grt", 32'(bus.issue_grt), exp_grt);
        chk("wid", 32'(bus.issue_wid), 32'(m_wid));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.issue_ack = 1'b0;
        bus.warp_rdy  = '0;

        // Reset state.
        step(1, 0, 0, 8'hFF);
        step(1, 0, 1, 8'hFF);
        chk("rst_vld", 32'(bus.issue_vld), 32'd0);
        chk("rst_grt", 32'(bus.issue_grt), 32'd0);

`ifndef GREEDY_EN
        // All ready, ack held: 0..7 then wrap to 0, first valid after one edge.
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 8'hFF);
            chk("rr_all_wid", 32'(bus.issue_wid), 32'(i % 8));
            chk("rr_all_vld", 32'(bus.issue_vld), 32'd1);
        end

        // Lower nibble ready, then nothing ready.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 8'h0F);
            chk("rr_nib_wid", 32'(bus.issue_wid), 32'(i % 4));
            chk("rr_nib_grt", 32'(bus.issue_grt), 32'd1 << (i % 4));
        end
        step(0, 0, 1, 8'h00);
        chk("empty_vld", 32'(bus.issue_vld), 32'd0);

        // Back-pressure holds warp 0, then the ack rotates to warp 2.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'h55);
            chk("hold_grt", 32'(bus.issue_grt), 32'h01);
        end
        step(0, 0, 1, 8'h55);
        chk("hold_next_wid", 32'(bus.issue_wid), 32'd2);

        // Flush with a simultaneous ack: drop the grant, no rotation.
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'hAA);
        chk("fl_pre_wid", 32'(bus.issue_wid), 32'd1);
        step(0, 1, 1, 8'hAA);
        chk("fl_vld", 32'(bus.issue_vld), 32'd0);
        step(0, 0, 0, 8'hAA);
        chk("fl_regrant_wid", 32'(bus.issue_wid), 32'd1);
`else
        // Greedy bursts of MAX_BURST per warp.
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 8'hFF);
            chk("gr_wid", 32'(bus.issue_wid), 32'(i / MB));
        end
        // Warp 2 drops ready while its first issue is acked: move to warp 3.
        step(0, 0, 1, 8'hFB);
        chk("gr_drop_wid", 32'(bus.issue_wid), 32'd3);
`endif

        // Reset in the middle of a HOLD, then scan restarts from 0.
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h03);
        step(0, 0, 1, 8'h20);
        step(0, 0, 0, 8'h20);
        chk("mid_hold_wid", 32'(bus.issue_wid), 32'd5);
        step(1, 1, 1, 8'hFF);
        chk("mid_rst_vld", 32'(bus.issue_vld), 32'd0);
        chk("mid_rst_wid", 32'(bus.issue_wid), 32'd0);
        step(0, 0, 0, 8'h80);
        chk("post_rst_wid", 32'(bus.issue_wid), 32'd7);
        chk("post_rst_grt", 32'(bus.issue_grt), 32'h80);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r_rdy;
            bit           r_rst;
            bit           r_fl;
            bit           r_ack;
            r_rdy = N'($urandom);
            if ($urandom_range(0, 3) == 0) r_rdy = r_rdy & N'($urandom);
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_ack = ($urandom_range(0, 2) != 0);
            step(r_rst, r_fl, r_ack, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
